isc_decode_queue: RTL and testbench

ISC_DECODE_QUEUE -- requirements
Module: isc_decode_queue

---
 rtl/isc_decode_queue.sv | 259 +++++++++++++++++++++++++
 tb/tb_isc_decode_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isc_decode_queue.sv
// ---------------------------------------------------------------------------
// hpu_common_instruction_pkg
//   Instruction word layout and decoded-entry types shared by the instruction
//   scheduler. The 32-bit word is read through three overlaid views:
//     pea_mac : kind[31:30] dop[29:24] dst_rid[23:17] src0_rid[16:10]
//               src1_rid[9:3] mul_factor[2:0]
//     pem     : kind[31:30] dop[29:24] rid[23:17] rsvd[16] cid[15:0]
//     pep     : kind[31:30] dop{rsvd[29:27] flush_pbs[26] log_lut_nb[25:24]}
//               dst_rid[23:17] src_rid[16:10] rsvd[9:0]
//
// isc_decode_queue
//   Decodes raw instructions at the input and queues the decoded entries,
//   each tagged with a running sequence number, in a DEPTH-slot FIFO.
//   Tracks occupancy, the number of queued PBS flushes and whether a SYNC
//   is queued. With SYNC_BARRIER=1 nothing is accepted behind a queued SYNC.
//
//   Ports
//     clk, a_rst          clock, asynchronous active-high reset
//     in_insn/in_vld/in_rdy  raw instruction handshake
//     out_kind/out_dst_id/out_srcA_id/out_srcB_id/out_flush/out_seq
//                         decoded head entry
//     out_vld/out_rdy     head entry handshake
//     occupancy           number of queued entries
//     flush_cnt           number of queued entries with flush=1
//     sync_pending        a SYNC entry is queued
// ---------------------------------------------------------------------------
package hpu_common_instruction_pkg;
   localparam int PE_INST_W   = 32;
   localparam int RID_W       = 7;
   localparam int CID_W       = 16;
   localparam int MAX_RID_MID = 16;
   localparam int DOP_W       = 6;

   localparam logic [DOP_W-1:0] DOP_ADD = 6'h00;
   localparam logic [DOP_W-1:0] DOP_SUB = 6'h02;
   localparam logic [DOP_W-1:0] DOP_MAC = 6'h04;

   typedef enum logic [2:0] {
      ARITH  = 3'd0,
      SYNC   = 3'd1,
      MEM_LD = 3'd2,
      MEM_ST = 3'd3,
      PBS    = 3'd4
   } insn_kind_e;

   typedef enum logic [1:0] {
      UNUSED   = 2'd0,
      REGISTER = 2'd1,
      MEMORY   = 2'd2
   } id_kind_e;

   typedef struct packed {
      id_kind_e               kind;
      logic [MAX_RID_MID-1:0] id;
   } insn_id_t;

   typedef struct packed {
      id_kind_e               kind;
      logic [MAX_RID_MID-1:0] id;
      logic [MAX_RID_MID-1:0] mask;
   } dstn_id_t;

   typedef struct packed {
      logic [1:0]       kind;
      logic [DOP_W-1:0] dop;
      logic [RID_W-1:0] dst_rid;
      logic [RID_W-1:0] src0_rid;
      logic [RID_W-1:0] src1_rid;
      logic [2:0]       mul_factor;
   } pea_mac_insn_t;

   typedef struct packed {
      logic [1:0]       kind;
      logic [DOP_W-1:0] dop;
      logic [RID_W-1:0] rid;
      logic             rsvd;
      logic [CID_W-1:0] cid;
   } pem_insn_t;

   typedef struct packed {
      logic [2:0] rsvd;
      logic       flush_pbs;
      logic [1:0] log_lut_nb;
   } pep_dop_t;

   typedef struct packed {
      logic [1:0]       kind;
      pep_dop_t         dop;
      logic [RID_W-1:0] dst_rid;
      logic [RID_W-1:0] src_rid;
      logic [9:0]       rsvd;
   } pep_insn_t;
endpackage

module isc_decode_queue #(
   parameter int PE_INST_W    = hpu_common_instruction_pkg::PE_INST_W,
   parameter int DEPTH        = 4,
   parameter int SEQ_W        = 8,
   parameter int SYNC_BARRIER = 1
) (
   input  logic                                     clk,
   input  logic                                     a_rst,
   input  logic [PE_INST_W-1:0]                     in_insn,
   input  logic                                     in_vld,
   output logic                                     in_rdy,
   output hpu_common_instruction_pkg::insn_kind_e   out_kind,
   output hpu_common_instruction_pkg::dstn_id_t     out_dst_id,
   output hpu_common_instruction_pkg::insn_id_t     out_srcA_id,
   output hpu_common_instruction_pkg::insn_id_t     out_srcB_id,
   output logic                                     out_flush,
   output logic [SEQ_W-1:0]                         out_seq,
   output logic                                     out_vld,
   input  logic                                     out_rdy,
   output logic [$clog2(DEPTH+1)-1:0]               occupancy,
   output logic [$clog2(DEPTH+1)-1:0]               flush_cnt,
   output logic                                     sync_pending
);
   import hpu_common_instruction_pkg::*;

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      insn_kind_e       kind;
      dstn_id_t         dst;
      insn_id_t         src_a;
      insn_id_t         src_b;
      logic             flush;
      logic [SEQ_W-1:0] seq;
   } entry_t;

   function automatic logic [MAX_RID_MID-1:0] rid_to_id(input logic [RID_W-1:0] rid);
      return {{(MAX_RID_MID-RID_W){1'b0}}, rid};
   endfunction

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   pea_mac_insn_t          pea;
   pem_insn_t              pem;
   pep_insn_t              pep;
   entry_t                 dec_p0;
   entry_t                 head_p1;
   entry_t                 mem_p1 [DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       occ_q;
   logic [CNT_W-1:0]       flush_q;
   logic [CNT_W-1:0]       sync_q;
   logic [SEQ_W-1:0]       seq_q;
   logic                   rdy_en;
   logic                   push;
   logic                   pop;
   logic                   unused_views;

   assign pea = in_insn;
   assign pem = in_insn;
   assign pep = in_insn;
   // Views overlap; not every field of every view feeds the decode.
   assign unused_views = ^{pea, pem, pep};

   // ---- stage p0: combinational decode of the incoming word ----
   always_comb begin
      dec_p0       = '0;
      dec_p0.kind  = ARITH;
      dec_p0.dst   = '{kind: REGISTER, id: rid_to_id(pea.dst_rid), mask: '1};
      dec_p0.src_a = '{kind: REGISTER, id: rid_to_id(pea.src0_rid)};
      dec_p0.src_b = '{kind: UNUSED, id: '0};
      dec_p0.flush = 1'b0;
      dec_p0.seq   = seq_q;

      case (in_insn[PE_INST_W-1 -: 2])
         2'b01: begin
            dec_p0.kind  = SYNC;
            dec_p0.dst   = '{kind: UNUSED, id: '0, mask: '1};
            dec_p0.src_a = '{kind: UNUSED, id: '0};
         end
         2'b10: begin
            if (pea.dop[0]) begin
               dec_p0.kind  = MEM_ST;
               dec_p0.dst   = '{kind: MEMORY, id: pem.cid, mask: '1};
               dec_p0.src_a = '{kind: REGISTER, id: rid_to_id(pem.rid)};
            end else begin
               dec_p0.kind  = MEM_LD;
               dec_p0.dst   = '{kind: REGISTER, id: rid_to_id(pem.rid), mask: '1};
               dec_p0.src_a = '{kind: MEMORY, id: pem.cid};
            end
         end
         2'b11: begin
            dec_p0.kind  = PBS;
            // Many-LUT PBS writes a block of 2^log_lut_nb registers.
            dec_p0.dst   = '{kind: REGISTER, id: rid_to_id(pep.dst_rid),
                             mask: {MAX_RID_MID{1'b1}} << pep.dop.log_lut_nb};
            dec_p0.flush = pep.dop.flush_pbs;
         end
         default: ;
      endcase

      // Second source depends on the operation code alone, whatever the kind.
      if (pea.dop == DOP_ADD || pea.dop == DOP_SUB || pea.dop == DOP_MAC)
         dec_p0.src_b = '{kind: REGISTER, id: rid_to_id(pea.src1_rid)};
   end

   // in_rdy is built from registered state only; rdy_en holds it low
   // during reset and until the first edge after release.
   assign sync_pending = (sync_q != '0);
   assign in_rdy       = rdy_en && (occ_q < CNT_W'(DEPTH)) &&
                         !((SYNC_BARRIER != 0) && sync_pending);
   assign out_vld      = (occ_q != '0);
   assign push         = in_vld && in_rdy;
   assign pop          = out_vld && out_rdy;

   // ---- stage p1: FIFO storage (data, no reset) ----
   always_ff @(posedge clk) begin
      if (push)
         mem_p1[wr_ptr] <= dec_p0;
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ_q   <= '0;
         flush_q <= '0;
         sync_q  <= '0;
         seq_q   <= '0;
         rdy_en  <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
            seq_q  <= seq_q + 1'b1;
         end
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: ;
         endcase
         flush_q <= flush_q + CNT_W'(push && dec_p0.flush)
                            - CNT_W'(pop && head_p1.flush);
         sync_q  <= sync_q + CNT_W'(push && (dec_p0.kind == SYNC))
                           - CNT_W'(pop && (head_p1.kind == SYNC));
      end
   end

   assign head_p1     = mem_p1[rd_ptr];
   assign out_kind    = head_p1.kind;
   assign out_dst_id  = head_p1.dst;
   assign out_srcA_id = head_p1.src_a;
   assign out_srcB_id = head_p1.src_b;
   assign out_flush   = head_p1.flush;
   assign out_seq     = head_p1.seq;
   assign occupancy   = occ_q;
   assign flush_cnt   = flush_q;
endmodule

// File: tb/tb_isc_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_isc_decode_queue
//   Table-driven decode vectors followed by hand-written sequences for the
//   full queue, SYNC barrier, sequence wrap, simultaneous push/pop and
//   asynchronous reset with entries queued.
// ---------------------------------------------------------------------------
module tb_isc_decode_queue;
   import hpu_common_instruction_pkg::*;

   localparam int DEPTH = 4;
   localparam int SEQ_W = 8;
   localparam int NV    = 9;

   localparam logic [1:0] IK_UNU = 2'd0;
   localparam logic [1:0] IK_REG = 2'd1;
   localparam logic [1:0] IK_MEM = 2'd2;

   localparam logic [2:0] K_ARITH = 3'd0;
   localparam logic [2:0] K_SYNC  = 3'd1;
   localparam logic [2:0] K_LD    = 3'd2;
   localparam logic [2:0] K_ST    = 3'd3;
   localparam logic [2:0] K_PBS   = 3'd4;

   logic              clk;
   logic              a_rst;
   logic [31:0]       in_insn;
   logic              in_vld;
   logic              in_rdy;
   insn_kind_e        out_kind;
   dstn_id_t          out_dst_id;
   insn_id_t          out_srcA_id;
   insn_id_t          out_srcB_id;
   logic              out_flush;
   logic [SEQ_W-1:0]  out_seq;
   logic              out_vld;
   logic              out_rdy;
   logic [2:0]        occupancy;
   logic [2:0]        flush_cnt;
   logic              sync_pending;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] insn;
      logic [2:0]  kind;
      logic [33:0] dst;
      logic [17:0] src_a;
      logic [17:0] src_b;
      logic        flush;
      logic        sync;
   } vec_t;

   vec_t vecs [NV];

   isc_decode_queue #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .SYNC_BARRIER(1)) dut (
      .clk          (clk),
      .a_rst        (a_rst),
      .in_insn      (in_insn),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .out_kind     (out_kind),
      .out_dst_id   (out_dst_id),
      .out_srcA_id  (out_srcA_id),
      .out_srcB_id  (out_srcB_id),
      .out_flush    (out_flush),
      .out_seq      (out_seq),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .occupancy    (occupancy),
      .flush_cnt    (flush_cnt),
      .sync_pending (sync_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk_arith(input logic [5:0] dop, input logic [6:0] dst,
                                            input logic [6:0] s0, input logic [6:0] s1);
      return {2'b00, dop, dst, s0, s1, 3'b000};
   endfunction

   function automatic logic [31:0] mk_mem(input logic [5:0] dop, input logic [6:0] rid,
                                          input logic [15:0] cid);
      return {2'b10, dop, rid, 1'b0, cid};
   endfunction

   function automatic logic [31:0] mk_pbs(input logic fl, input logic [1:0] lln,
                                          input logic [6:0] dst, input logic [6:0] src);
      return {2'b11, 3'b000, fl, lln, dst, src, 10'd0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      in_insn = '0;
      a_rst   = 1'b1;
      tick();
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
      chk("rst_sync", 64'(sync_pending), 64'd0);
      a_rst = 1'b0;
      tick();
      chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);
   endtask

   initial begin
      a_rst   = 1'b1;
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      in_insn = '0;

      //                insn                             kind     dst                           srcA                 srcB                 fl    sync
      vecs[0] = '{mk_arith(6'h00, 7'd10, 7'd11, 7'd12), K_ARITH, {IK_REG, 16'd10, 16'hFFFF},  {IK_REG, 16'd11},    {IK_REG, 16'd12},    1'b0, 1'b0};
      vecs[1] = '{mk_arith(6'h07, 7'd1, 7'd2, 7'd3),    K_ARITH, {IK_REG, 16'd1, 16'hFFFF},   {IK_REG, 16'd2},     {IK_UNU, 16'd0},     1'b0, 1'b0};
      vecs[2] = '{mk_arith(6'h02, 7'd127, 7'd0, 7'd127), K_ARITH, {IK_REG, 16'd127, 16'hFFFF}, {IK_REG, 16'd0},    {IK_REG, 16'd127},   1'b0, 1'b0};
      vecs[3] = '{mk_arith(6'h04, 7'd9, 7'd8, 7'd7),    K_ARITH, {IK_REG, 16'd9, 16'hFFFF},   {IK_REG, 16'd8},     {IK_REG, 16'd7},     1'b0, 1'b0};
      vecs[4] = '{mk_mem(6'h01, 7'd3, 16'd9),           K_ST,    {IK_MEM, 16'd9, 16'hFFFF},   {IK_REG, 16'd3},     {IK_UNU, 16'd0},     1'b0, 1'b0};
      vecs[5] = '{mk_mem(6'h06, 7'd5, 16'h1234),        K_LD,    {IK_REG, 16'd5, 16'hFFFF},   {IK_MEM, 16'h1234},  {IK_UNU, 16'd0},     1'b0, 1'b0};
      vecs[6] = '{mk_pbs(1'b1, 2'd2, 7'd5, 7'd8),       K_PBS,   {IK_REG, 16'd5, 16'hFFFC},   {IK_REG, 16'd8},     {IK_UNU, 16'd0},     1'b1, 1'b0};
      vecs[7] = '{mk_pbs(1'b0, 2'd3, 7'd7, 7'd1),       K_PBS,   {IK_REG, 16'd7, 16'hFFF8},   {IK_REG, 16'd1},     {IK_UNU, 16'd0},     1'b0, 1'b0};
      vecs[8] = '{32'h4000_0000,                        K_SYNC,  {IK_UNU, 16'd0, 16'hFFFF},   {IK_UNU, 16'd0},     {IK_REG, 16'd0},     1'b0, 1'b1};

      do_reset();

      // Decode table: one entry at a time through an empty queue.
      for (int i = 0; i < NV; i++) begin
         chk("vec_in_rdy", 64'(in_rdy), 64'd1);
         in_insn = vecs[i].insn;
         in_vld  = 1'b1;
         tick();
         in_vld  = 1'b0;
         chk("vec_out_vld", 64'(out_vld), 64'd1);
         chk("vec_kind", 64'(out_kind), 64'(vecs[i].kind));
         chk("vec_dst", 64'(out_dst_id), 64'(vecs[i].dst));
         chk("vec_srcA", 64'(out_srcA_id), 64'(vecs[i].src_a));
         chk("vec_srcB", 64'(out_srcB_id), 64'(vecs[i].src_b));
         chk("vec_flush", 64'(out_flush), 64'(vecs[i].flush));
         chk("vec_flush_cnt", 64'(flush_cnt), 64'(vecs[i].flush));
         chk("vec_sync", 64'(sync_pending), 64'(vecs[i].sync));
         chk("vec_seq", 64'(out_seq), 64'(i));
         chk("vec_occ", 64'(occupancy), 64'd1);
         out_rdy = 1'b1;
         tick();
         out_rdy = 1'b0;
         chk("vec_pop_vld", 64'(out_vld), 64'd0);
         chk("vec_pop_flush_cnt", 64'(flush_cnt), 64'd0);
      end

      // Simultaneous push and pop adjusts flush_cnt by pushed minus popped.
      in_vld  = 1'b1;
      in_insn = mk_pbs(1'b1, 2'd0, 7'd1, 7'd1);
      tick();
      chk("pp_flush1", 64'(flush_cnt), 64'd1);
      in_insn = mk_pbs(1'b0, 2'd0, 7'd2, 7'd2);
      out_rdy = 1'b1;
      tick();
      chk("pp_occ_a", 64'(occupancy), 64'd1);
      chk("pp_flush_a", 64'(flush_cnt), 64'd0);
      in_insn = mk_pbs(1'b1, 2'd0, 7'd3, 7'd3);
      tick();
      chk("pp_occ_b", 64'(occupancy), 64'd1);
      chk("pp_flush_b", 64'(flush_cnt), 64'd1);
      chk("pp_head_dst", 64'(out_dst_id.id), 64'd3);
      in_vld = 1'b0;
      tick();
      out_rdy = 1'b0;
      chk("pp_drain", 64'(occupancy), 64'd0);

      // Fill to DEPTH, free one slot, drain in order.
      do_reset();
      in_vld = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         in_insn = mk_arith(6'h07, 7'(20 + k), 7'd0, 7'd0);
         tick();
      end
      in_vld = 1'b0;
      chk("full_occ", 64'(occupancy), 64'd4);
      chk("full_in_rdy", 64'(in_rdy), 64'd0);
      chk("full_head_seq", 64'(out_seq), 64'd0);
      chk("full_head_dst", 64'(out_dst_id.id), 64'd20);
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      chk("free_in_rdy", 64'(in_rdy), 64'd1);
      chk("free_occ", 64'(occupancy), 64'd3);
      out_rdy = 1'b1;
      for (int k = 1; k < DEPTH; k++) begin
         chk("drain_vld", 64'(out_vld), 64'd1);
         chk("drain_seq", 64'(out_seq), 64'(k));
         chk("drain_dst", 64'(out_dst_id.id), 64'(20 + k));
         tick();
      end
      out_rdy = 1'b0;
      chk("drain_empty", 64'(out_vld), 64'd0);

      // SYNC barrier holds off the following ARITH until the SYNC pops.
      do_reset();
      in_insn = 32'h4000_0000;
      in_vld  = 1'b1;
      tick();
      in_insn = mk_arith(6'h00, 7'd44, 7'd1, 7'd2);
      chk("bar_sync", 64'(sync_pending), 64'd1);
      chk("bar_in_rdy", 64'(in_rdy), 64'd0);
      tick();
      tick();
      chk("bar_held_occ", 64'(occupancy), 64'd1);
      chk("bar_head_kind", 64'(out_kind), 64'(K_SYNC));
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      chk("bar_release_rdy", 64'(in_rdy), 64'd1);
      chk("bar_release_occ", 64'(occupancy), 64'd0);
      chk("bar_release_sync", 64'(sync_pending), 64'd0);
      tick();
      in_vld = 1'b0;
      chk("bar_arith_vld", 64'(out_vld), 64'd1);
      chk("bar_arith_kind", 64'(out_kind), 64'(K_ARITH));
      chk("bar_arith_seq", 64'(out_seq), 64'd1);
      chk("bar_arith_dst", 64'(out_dst_id.id), 64'd44);

      // Sequence wrap: 258 accepts streamed straight through.
      do_reset();
      in_insn = mk_arith(6'h07, 7'd1, 7'd1, 7'd1);
      in_vld  = 1'b1;
      out_rdy = 1'b1;
      for (int j = 1; j <= 258; j++) begin
         tick();
         if (j == 256) chk("wrap_seq_255", 64'(out_seq), 64'd255);
         if (j == 257) chk("wrap_seq_0", 64'(out_seq), 64'd0);
         if (j == 258) begin
            chk("wrap_seq_1", 64'(out_seq), 64'd1);
            chk("wrap_occ", 64'(occupancy), 64'd1);
         end
      end
      in_vld = 1'b0;
      tick();
      out_rdy = 1'b0;

      // Asynchronous reset with three entries queued.
      do_reset();
      in_vld  = 1'b1;
      in_insn = mk_pbs(1'b1, 2'd2, 7'd5, 7'd8);
      tick();
      in_insn = mk_arith(6'h00, 7'd1, 7'd2, 7'd3);
      tick();
      in_insn = 32'h4000_0000;
      tick();
      in_vld = 1'b0;
      chk("ar_occ", 64'(occupancy), 64'd3);
      chk("ar_flush_cnt", 64'(flush_cnt), 64'd1);
      chk("ar_sync", 64'(sync_pending), 64'd1);
      #2;
      a_rst = 1'b1;
      #1;
      chk("ar_out_vld", 64'(out_vld), 64'd0);
      chk("ar_in_rdy", 64'(in_rdy), 64'd0);
      chk("ar_occ0", 64'(occupancy), 64'd0);
      chk("ar_flush0", 64'(flush_cnt), 64'd0);
      chk("ar_sync0", 64'(sync_pending), 64'd0);
      tick();
      a_rst = 1'b0;
      tick();
      chk("ar_rel_in_rdy", 64'(in_rdy), 64'd1);
      chk("ar_rel_vld", 64'(out_vld), 64'd0);
      tick();
      chk("ar_no_stale", 64'(out_vld), 64'd0);
      in_insn = mk_arith(6'h07, 7'd30, 7'd0, 7'd0);
      in_vld  = 1'b1;
      tick();
      in_vld = 1'b0;
      chk("ar_new_seq", 64'(out_seq), 64'd0);
      chk("ar_new_dst", 64'(out_dst_id.id), 64'd30);
      chk("ar_new_occ", 64'(occupancy), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
